keypad_emulator: RTL
====================

Name: keypad_emulator

Overview:
- Responder end of the 4x4 keypad port: watches the active-low column drive from the keypad decoder and drives the active-low row lines back, exactly as a physical keypad with one pressed key would.
- Press requests arrive over a valid/ready handshake and are played out with deterministic contact bounce, hold time and release gap.
- Used in the combo-lock self-test build and as the keypad model in benches.

Parameters:
- HOLD_CYCLES, 1000000, cycles the contact is stably closed (>=1)
- BOUNCE_CYCLES, 20000, length of each bounce window at press and release; 0 = no bounce states
- BOUNCE_TOGGLE, 1000, contact toggles every BOUNCE_TOGGLE cycles inside a bounce window (>=1)
- GAP_CYCLES, 1000000, cycles of open contact after release before the next request is accepted (>=1)

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-high
- col_n  in  4  column drive from decoder, active-low; bit3 = left column (1,4,7,0)
- row_n  out  4  row lines to decoder, active-low; bit3 = top row (1,2,3,A)
- req_valid  in  1  press request valid
- req_key  in  4  hex code of key to press
- req_ready  out  1  high only in IDLE
- abort  in  1  force immediate release
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when GAP completes

Behaviour:
- Reset: async clear of everything. row_n=4'hF, req_ready=1, busy=0, done=0, state=IDLE, contact=0.
- Key map (row, col) where 0 = bit3:
  - row 0: 1, 2, 3, A
  - row 1: 4, 5, 6, B
  - row 2: 7, 8, 9, C
  - row 3: 0, F, E, D
- Row drive: registered, 1-cycle latency from col_n.
  - row_n[r]=0 iff contact=1, r = latched row, and col_n at latched column = 0. All other row bits are 1.
  - Multiple columns low: the pressed key still pulls its row if its column is among them.
- States: IDLE -> BOUNCE_IN -> HOLD -> BOUNCE_OUT -> GAP -> IDLE.
  - IDLE: accept on req_valid & req_ready. Latch req_key. Load counter. Go to BOUNCE_IN, or straight to HOLD if BOUNCE_CYCLES=0.
  - BOUNCE_IN: contact starts at 1 and inverts every BOUNCE_TOGGLE cycles. After exactly BOUNCE_CYCLES cycles go to HOLD.
  - HOLD: contact=1 for exactly HOLD_CYCLES cycles.
  - BOUNCE_OUT: contact starts at 0 and inverts every BOUNCE_TOGGLE cycles for BOUNCE_CYCLES cycles. Skipped if BOUNCE_CYCLES=0.
  - GAP: contact=0 for GAP_CYCLES cycles. On exit, done=1 for one cycle coincident with return to IDLE; req_ready rises the same cycle.
- Counters: one 32-bit down-counter for state duration, one 32-bit down-counter for toggle period. Parameters must fit in 32 bits.
- abort, any non-IDLE state other than GAP: contact=0 next cycle, go to GAP with full GAP_CYCLES. done still pulses at the end.
- abort in GAP: ignored. abort together with req_valid in IDLE: abort wins and no request is accepted.
- req_valid while busy: ignored; no queueing. req_key is sampled only on the accept cycle.
- Reset mid-press: rows release asynchronously (row_n=F); the request is dropped.

Decomposition:
- Shared package keypad_pkg holds:
  - key code constants
  - the key-to-row/column function, shared with the decoder
  - the state enum localparams
- No sub-module. The toggle generator stays inline.

Test Plan:
- Reset, then any col_n pattern -> row_n=F, req_ready=1, busy=0.
- BOUNCE_CYCLES=0, HOLD=8, GAP=4. Request key 5, col_n scanned 7,B,D,E -> row_n=B only while col_n=B, exactly 8 cycles after accept. done pulses 12 cycles after HOLD entry + 4.
- Key D, BOUNCE_CYCLES=6, TOGGLE=2, col_n held E -> row_n[0] pattern 0,0,1,1,0,0 during BOUNCE_IN, then steady 0 for HOLD, then 1,1,0,0,1,1 during BOUNCE_OUT.
- abort asserted 3 cycles into HOLD (key 1, col_n=7) -> row_n=F the next registered cycle. GAP runs full length, then done pulses once.
- Second req_valid while busy with key 9 -> ignored; req_ready stays 0. A request after done presses the new key only.
- Reset asserted mid-HOLD -> row_n=F asynchronously. After deassertion: IDLE, req_ready=1, no done pulse.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key codes, key-to-matrix mapping and the
// emulator state encoding. Also used by the keypad decoder.
package keypad_pkg;

  localparam logic [3:0] KEY_0 = 4'h0;
  localparam logic [3:0] KEY_1 = 4'h1;
  localparam logic [3:0] KEY_2 = 4'h2;
  localparam logic [3:0] KEY_3 = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4;
  localparam logic [3:0] KEY_5 = 4'h5;
  localparam logic [3:0] KEY_6 = 4'h6;
  localparam logic [3:0] KEY_7 = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h8;
  localparam logic [3:0] KEY_9 = 4'h9;
  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] KEY_D = 4'hD;
  localparam logic [3:0] KEY_E = 4'hE;
  localparam logic [3:0] KEY_F = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_BOUNCE_IN  = 3'd1,
    ST_HOLD       = 3'd2,
    ST_BOUNCE_OUT = 3'd3,
    ST_GAP        = 3'd4
  } state_t;

  // Row/column index 0 is the top row / left column, i.e. bit 3 of row_n / col_n.
  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } key_pos_t;

  function automatic key_pos_t key_to_pos(input logic [3:0] key);
    key_pos_t pos;
    case (key)
      KEY_1:   pos = '{row: 2'd0, col: 2'd0};
      KEY_2:   pos = '{row: 2'd0, col: 2'd1};
      KEY_3:   pos = '{row: 2'd0, col: 2'd2};
      KEY_A:   pos = '{row: 2'd0, col: 2'd3};
      KEY_4:   pos = '{row: 2'd1, col: 2'd0};
      KEY_5:   pos = '{row: 2'd1, col: 2'd1};
      KEY_6:   pos = '{row: 2'd1, col: 2'd2};
      KEY_B:   pos = '{row: 2'd1, col: 2'd3};
      KEY_7:   pos = '{row: 2'd2, col: 2'd0};
      KEY_8:   pos = '{row: 2'd2, col: 2'd1};
      KEY_9:   pos = '{row: 2'd2, col: 2'd2};
      KEY_C:   pos = '{row: 2'd2, col: 2'd3};
      KEY_0:   pos = '{row: 2'd3, col: 2'd0};
      KEY_F:   pos = '{row: 2'd3, col: 2'd1};
      KEY_E:   pos = '{row: 2'd3, col: 2'd2};
      KEY_D:   pos = '{row: 2'd3, col: 2'd3};
      default: pos = '{row: 2'd3, col: 2'd0};
    endcase
    return pos;
  endfunction

endpackage

// File: rtl/keypad_emulator.sv
// Responder side of a 4x4 active-low keypad matrix: plays out one key press
// per request with deterministic bounce, hold and release gap.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 1000000,
  parameter int unsigned BOUNCE_CYCLES = 20000,
  parameter int unsigned BOUNCE_TOGGLE = 1000,
  parameter int unsigned GAP_CYCLES    = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  input  logic       req_valid,
  input  logic [3:0] req_key,
  output logic       req_ready,
  input  logic       abort,
  output logic       busy,
  output logic       done
);

  localparam logic [31:0] HOLD_LOAD   = 32'(HOLD_CYCLES);
  localparam logic [31:0] BOUNCE_LOAD = 32'(BOUNCE_CYCLES);
  localparam logic [31:0] TOGGLE_LOAD = 32'(BOUNCE_TOGGLE);
  localparam logic [31:0] GAP_LOAD    = 32'(GAP_CYCLES);
  localparam bit          HAS_BOUNCE  = (BOUNCE_CYCLES != 0);

  state_t      state_r;
  logic [31:0] dur_cnt_r;
  logic [31:0] tog_cnt_r;
  logic        contact_r;
  key_pos_t    pos_r;
  logic        req_ready_r;
  logic        busy_r;
  logic        done_r;
  logic [3:0]  row_n_r;
  logic [3:0]  row_next_s;

  // Press sequencer: state duration, bounce toggling and handshake outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      dur_cnt_r   <= 32'd0;
      tog_cnt_r   <= 32'd0;
      contact_r   <= 1'b0;
      pos_r       <= '{row: 2'd0, col: 2'd0};
      req_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // abort takes priority over a coincident request
          if (req_valid && !abort) begin
            pos_r       <= key_to_pos(req_key);
            contact_r   <= 1'b1;
            tog_cnt_r   <= TOGGLE_LOAD;
            req_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            if (HAS_BOUNCE) begin
              state_r   <= ST_BOUNCE_IN;
              dur_cnt_r <= BOUNCE_LOAD;
            end else begin
              state_r   <= ST_HOLD;
              dur_cnt_r <= HOLD_LOAD;
            end
          end
        end
        ST_BOUNCE_IN: begin
          if (abort) begin
            state_r   <= ST_GAP;
            dur_cnt_r <= GAP_LOAD;
            contact_r <= 1'b0;
          end else if (dur_cnt_r == 32'd1) begin
            state_r   <= ST_HOLD;
            dur_cnt_r <= HOLD_LOAD;
            contact_r <= 1'b1;
          end else begin
            dur_cnt_r <= dur_cnt_r - 32'd1;
            if (tog_cnt_r == 32'd1) begin
              contact_r <= ~contact_r;
              tog_cnt_r <= TOGGLE_LOAD;
            end else begin
              tog_cnt_r <= tog_cnt_r - 32'd1;
            end
          end
        end
        ST_HOLD: begin
          if (abort) begin
            state_r   <= ST_GAP;
            dur_cnt_r <= GAP_LOAD;
            contact_r <= 1'b0;
          end else if (dur_cnt_r == 32'd1) begin
            contact_r <= 1'b0;
            tog_cnt_r <= TOGGLE_LOAD;
            if (HAS_BOUNCE) begin
              state_r   <= ST_BOUNCE_OUT;
              dur_cnt_r <= BOUNCE_LOAD;
            end else begin
              state_r   <= ST_GAP;
              dur_cnt_r <= GAP_LOAD;
            end
          end else begin
            dur_cnt_r <= dur_cnt_r - 32'd1;
          end
        end
        ST_BOUNCE_OUT: begin
          if (abort || (dur_cnt_r == 32'd1)) begin
            state_r   <= ST_GAP;
            dur_cnt_r <= GAP_LOAD;
            contact_r <= 1'b0;
          end else begin
            dur_cnt_r <= dur_cnt_r - 32'd1;
            if (tog_cnt_r == 32'd1) begin
              contact_r <= ~contact_r;
              tog_cnt_r <= TOGGLE_LOAD;
            end else begin
              tog_cnt_r <= tog_cnt_r - 32'd1;
            end
          end
        end
        ST_GAP: begin
          if (dur_cnt_r == 32'd1) begin
            state_r     <= ST_IDLE;
            done_r      <= 1'b1;
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
          end else begin
            dur_cnt_r <= dur_cnt_r - 32'd1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          contact_r   <= 1'b0;
          req_ready_r <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  // A closed contact shorts the latched column onto the latched row
  always_comb begin
    row_next_s = 4'hF;
    if (contact_r && (col_n[2'd3 - pos_r.col] == 1'b0)) begin
      row_next_s[2'd3 - pos_r.row] = 1'b0;
    end else begin
      row_next_s = 4'hF;
    end
  end

  // Registered row drive, released immediately on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_n_r <= 4'hF;
    end else begin
      row_n_r <= row_next_s;
    end
  end

  assign row_n     = row_n_r;
  assign req_ready = req_ready_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule
